// File: rtl/multdiv_sequencer.sv
// Multicycle signed multiply/divide sequencer driving one shared add/subtract-and-shift datapath.
// The pipeline stalls on busy and resumes on data_resultRDY.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t               state, next_state;
    logic                 op_div;
    logic [WIDTH-1:0]     operand_a, operand_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 neg_result;
    logic [2*WIDTH-1:0]   work;
    logic [CW-1:0]        counter;

    logic [CW-1:0]        bit_idx;
    logic [WIDTH:0]       add_x, add_y, add_sum;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     quot_signed;
    logic [WIDTH-1:0]     fix_result;
    logic                 fix_exception;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (ctrl_MULT || ctrl_DIV) next_state = PREP;
            PREP: next_state = RUN;
            RUN:  if (counter == LAST) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One adder serves both ops: shift-add for multiply, trial subtract for restoring divide.
    always_comb begin
        bit_idx = LAST - counter;
        if (op_div) begin
            add_x   = {work[2*WIDTH-1:WIDTH], mag_a[bit_idx]};
            add_y   = {1'b0, mag_b};
            add_sum = add_x - add_y;
        end else begin
            add_x   = {1'b0, work[2*WIDTH-1:WIDTH]};
            add_y   = mag_b[counter] ? {1'b0, mag_a} : '0;
            add_sum = add_x + add_y;
        end
    end

    always_comb begin
        prod_signed   = neg_result ? (~work + 1'b1) : work;
        quot_signed   = neg_result ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
        fix_result    = '0;
        fix_exception = 1'b0;
        if (op_div) begin
            if (mag_b == '0) begin
                fix_result    = '0;
                fix_exception = 1'b1;
            end else begin
                // A positive quotient with the top bit set only arises from -2^(W-1) / -1.
                fix_result    = quot_signed;
                fix_exception = !neg_result && work[WIDTH-1];
            end
        end else begin
            fix_result    = prod_signed[WIDTH-1:0];
            fix_exception = !((&prod_signed[2*WIDTH-1:WIDTH-1]) ||
                              (~|prod_signed[2*WIDTH-1:WIDTH-1]));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_div         <= 1'b0;
            operand_a      <= '0;
            operand_b      <= '0;
            mag_a          <= '0;
            mag_b          <= '0;
            neg_result     <= 1'b0;
            work           <= '0;
            counter        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        op_div    <= !ctrl_MULT;
                        operand_a <= data_operandA;
                        operand_b <= data_operandB;
                    end
                end
                PREP: begin
                    mag_a      <= operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
                    mag_b      <= operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;
                    neg_result <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    work       <= '0;
                    counter    <= '0;
                end
                RUN: begin
                    if (op_div) begin
                        work <= {add_sum[WIDTH] ? add_x[WIDTH-1:0] : add_sum[WIDTH-1:0],
                                 work[WIDTH-2:0], ~add_sum[WIDTH]};
                    end else begin
                        work <= {add_sum, work[WIDTH-1:1]};
                    end
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    data_result    <= fix_result;
                    data_exception <= fix_exception;
                    data_resultRDY <= 1'b1;
                end
                DONE: begin
                    data_resultRDY <= 1'b0;
                end
                default: begin
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer: signed multiply/divide results,
// exceptions, latency, ignored starts and asynchronous abort.
module tb_multdiv_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv_sequencer #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Returns just after the start edge E0; operands are scrambled to prove they were latched.
    task automatic applyStimulus(input logic m, input logic d,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1357_9BDF;
    endtask

    task automatic waitResult(input int start, output int n);
        n = start;
        while (n < 80) begin
            @(posedge clock);
            n++;
            #1;
            if (data_resultRDY) break;
        end
    endtask

    task automatic finishOp(input string tag, input int n,
                            input logic [31:0] exp_result, input logic exp_exc);
        checkOutput({tag, "_latency"}, 64'(n), 64'd34);
        checkOutput({tag, "_result"}, 64'(data_result), 64'(exp_result));
        checkOutput({tag, "_exception"}, 64'(data_exception), 64'(exp_exc));
        checkOutput({tag, "_busy_done"}, 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        checkOutput({tag, "_rdy_pulse"}, 64'(data_resultRDY), 64'd0);
        checkOutput({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_result, input logic exp_exc);
        int n;
        applyStimulus(m, d, a, b);
        waitResult(0, n);
        finishOp(tag, n, exp_result, exp_exc);
    endtask

    initial begin
        int n;
        logic seen;

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_result", 64'(data_result), 64'd0);
        checkOutput("reset_exception", 64'(data_exception), 64'd0);
        checkOutput("reset_rdy", 64'(data_resultRDY), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        $display("[TB] reset released");

        runOp("t1_mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        runOp("t2_mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        repeat (9) @(posedge clock);
        #1;
        checkOutput("t2_hold_result", 64'(data_result), 64'd0);
        checkOutput("t2_hold_exception", 64'(data_exception), 64'd1);
        checkOutput("t2_busy_run", 64'(busy), 64'd1);
        waitResult(9, n);
        finishOp("t2_mul_min", n, 32'h8000_0000, 1'b0);

        runOp("t3_div_-100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        runOp("t3_div_100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        runOp("t3_div_1000/10", 1'b0, 1'b1, 32'd1000, 32'd10, 32'd100, 1'b0);
        runOp("t4_div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        runOp("t4_div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // A divide request and new operands mid-run must not disturb the multiply.
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd99;
        data_operandB = 32'd5;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        waitResult(10, n);
        finishOp("t5_ignore_start", n, 32'd12, 1'b0);

        runOp("t5_both_starts", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'd1000, 32'd10);
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_abort_result", 64'(data_result), 64'd0);
        checkOutput("t6_abort_exception", 64'(data_exception), 64'd0);
        checkOutput("t6_abort_rdy", 64'(data_resultRDY), 64'd0);
        checkOutput("t6_abort_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            seen = seen | data_resultRDY | busy;
        end
        checkOutput("t6_no_rdy_after_abort", 64'(seen), 64'd0);

        runOp("t6_mul_2x2", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
